// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the accumulator CPU.
//   opcode_e  - 3-bit opcode encoding, shared with the ALU.
//   state_e   - sequencer state; 0..7 are the instruction phases and HALTED
//               sits outside that range so it never aliases a phase.
//   is_aluop  - true for opcodes whose result is captured by the accumulator.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  localparam logic [2:0] HALTED_PHASE = 3'd3;

  function automatic logic is_aluop(opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for the accumulator CPU.
//   clk, rst_n       - clock (rising edge), async active-low reset
//   opcode, zero     - IR opcode and ALU zero flag
//   resume           - leave HALTED (only when HALT_STICKY == 0)
//   mem_rd, mem_wr   - memory strobes
//   load_ir          - instruction register load
//   inc_pc, load_pc  - program counter increment / jump load
//   load_ac          - accumulator capture of ALU result
//   halt             - processor halted
//   phase            - current phase 0-7 (HALTED reports 3)
// The state register is the only storage; all outputs decode from state
// and opcode combinationally.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       resume,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_ac,
  output logic       halt,
  output logic [2:0] phase
);

  state_e  state, state_nxt;
  opcode_e op;
  logic    aluop;

  assign op    = opcode_e'(opcode);
  assign aluop = is_aluop(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INST_ADDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = INST_ADDR;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    load_ir   = 1'b0;
    inc_pc    = 1'b0;
    load_pc   = 1'b0;
    load_ac   = 1'b0;
    halt      = 1'b0;
    phase     = 3'd0;
    case (state)
      INST_ADDR: begin
        state_nxt = INST_FETCH;
        phase     = 3'd0;
      end
      INST_FETCH: begin
        state_nxt = INST_LOAD;
        phase     = 3'd1;
        mem_rd    = 1'b1;
      end
      INST_LOAD: begin
        state_nxt = IDLE;
        phase     = 3'd2;
        mem_rd    = 1'b1;
        load_ir   = 1'b1;
      end
      IDLE: begin
        state_nxt = OP_ADDR;
        phase     = 3'd3;
        mem_rd    = 1'b1;
        load_ir   = 1'b1;
      end
      OP_ADDR: begin
        // The only branch in the cycle: HLT diverts to HALTED.
        state_nxt = (op == HLT) ? HALTED : OP_FETCH;
        phase     = 3'd4;
        inc_pc    = (op != HLT);
        halt      = (op == HLT);
      end
      OP_FETCH: begin
        state_nxt = ALU_OP;
        phase     = 3'd5;
        mem_rd    = aluop;
      end
      ALU_OP: begin
        state_nxt = STORE;
        phase     = 3'd6;
        mem_rd    = aluop;
        load_ac   = aluop;
        // zero only matters here, for the SKZ skip.
        inc_pc    = (op == SKZ) && zero;
        load_pc   = (op == JMP);
      end
      STORE: begin
        state_nxt = INST_ADDR;
        phase     = 3'd7;
        mem_rd    = aluop;
        load_ac   = aluop;
        load_pc   = (op == JMP);
        inc_pc    = (op == JMP);
        mem_wr    = (op == STO);
      end
      HALTED: begin
        state_nxt = (!HALT_STICKY && resume) ? INST_ADDR : HALTED;
        phase     = HALTED_PHASE;
        halt      = 1'b1;
      end
      // Unreachable encodings recover to INST_ADDR with everything low.
      default: state_nxt = INST_ADDR;
    endcase
  end

endmodule
